// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus register-file write/read-check signals shared by the arbiter.
// master = requesters and register file side; slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      A1;
  logic [AW-1:0]      A2;
  logic               WE3;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD3;
  logic               pc_we;
  logic [DW-1:0]      pc_wd;
  logic               stall;

  modport master (
    output req, addr, data, A1, A2,
    input  gnt, WE3, A3, WD3, pc_we, pc_wd, stall
  );

  modport slave (
    input  req, addr, data, A1, A2,
    output gnt, WE3, A3, WD3, pc_we, pc_wd, stall
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port; R15 writes are diverted to pc_we/pc_wd.
// Grant to WE3/pc_we takes one cycle, one grant per cycle; losers hold req until granted.
module regfile_write_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic [NREQ-1:0] gnt_c;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            we3_q;
  logic [AW-1:0]   a3_q;
  logic [DW-1:0]   wd3_q;
  logic            pc_we_q;
  logic [DW-1:0]   pc_wd_q;
  logic            stall_c;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = bus.addr[g*AW +: AW];
    assign data_a[g] = bus.data[g*DW +: DW];
  end

  // Search begins just after the last winner, so the previous winner ends up lowest priority.
  always_comb begin
    int idx;
    gnt_c   = '0;
    win_idx = rr_ptr;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld    = 1'b1;
        win_idx    = PW'(idx);
        gnt_c[idx] = 1'b1;
      end
    end
    if (reset) begin
      gnt_c   = '0;
      win_vld = 1'b0;
    end
  end

  assign win_addr = addr_a[win_idx];
  assign win_data = data_a[win_idx];

  // Pending requests count as in-flight writes, as does the one sitting in the output stage.
  always_comb begin
    stall_c = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (bus.req[j] && addr_a[j] != PC_ADDR &&
          (addr_a[j] == bus.A1 || addr_a[j] == bus.A2))
        stall_c = 1'b1;
    end
    if (we3_q && a3_q != PC_ADDR && (a3_q == bus.A1 || a3_q == bus.A2))
      stall_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= PW'(NREQ - 1);
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      pc_we_q <= 1'b0;
      pc_wd_q <= '0;
    end else begin
      we3_q   <= 1'b0;
      pc_we_q <= 1'b0;
      if (win_vld) begin
        rr_ptr <= win_idx;
        if (win_addr == PC_ADDR) begin
          pc_we_q <= 1'b1;
          pc_wd_q <= win_data;
        end else begin
          we3_q <= 1'b1;
          a3_q  <= win_addr;
          wd3_q <= win_data;
        end
      end
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.WE3   = we3_q;
  assign bus.A3    = a3_q;
  assign bus.WD3   = wd3_q;
  assign bus.pc_we = pc_we_q;
  assign bus.pc_wd = pc_wd_q;
  assign bus.stall = stall_c;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_regfile_write_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus state
  logic [NREQ-1:0] req_v;
  logic [AW-1:0]   addr_v [NREQ];
  logic [DW-1:0]   data_v [NREQ];
  logic [AW-1:0]   a1_v;
  logic [AW-1:0]   a2_v;
  int              waitc  [NREQ];
  logic [DW-1:0]   obs_rf [16];

  // reference model: last winner index and what the output stage should show
  int            m_last;
  logic          m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;
  logic          m_pcwe;
  logic [DW-1:0] m_pcwd;

  task automatic drive();
    bus.req = req_v;
    bus.A1  = a1_v;
    bus.A2  = a2_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.addr[i*AW +: AW] = addr_v[i];
      bus.data[i*DW +: DW] = data_v[i];
    end
  endtask

  task automatic set_req(input logic [NREQ-1:0] r, input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_v     = r;
    addr_v[0] = ad0;
    addr_v[1] = ad1;
    data_v[0] = d0;
    data_v[1] = d1;
    drive();
  endtask

  function automatic int exp_winner();
    if (reset) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (req_v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic hazard_on(input logic [AW-1:0] x);
    if (x == AW'(15)) return 1'b0;
    if (m_we && m_a3 == x) return 1'b1;
    for (int j = 0; j < NREQ; j++)
      if (req_v[j] && addr_v[j] == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clock();
    int w;
    w = exp_winner();
    if (reset) begin
      m_last = NREQ - 1;
      m_we   = 1'b0;
      m_a3   = '0;
      m_wd3  = '0;
      m_pcwe = 1'b0;
      m_pcwd = '0;
    end else begin
      m_we   = 1'b0;
      m_pcwe = 1'b0;
      if (w >= 0) begin
        m_last = w;
        if (addr_v[w] == AW'(15)) begin
          m_pcwe = 1'b1;
          m_pcwd = data_v[w];
        end else begin
          m_we  = 1'b1;
          m_a3  = addr_v[w];
          m_wd3 = data_v[w];
        end
      end
    end
  endtask

  // Called at the negedge: record what the register file commits, step the model, cross the posedge.
  task automatic advance();
    if (bus.WE3) obs_rf[bus.A3] = bus.WD3;
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    advance();
    reset = 1'b0;
    drive();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a1_v  = 0;
    a2_v  = 0;
    set_req(2'b11, 1, 2, 32'h10, 32'h20);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt actual=%b expected=00", bus.gnt); end
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 actual=%b expected=0", bus.WE3); end
    checks++; if (bus.pc_we !== 1'b0) begin failures++; $display("FAIL reset_pc_we actual=%b expected=0", bus.pc_we); end
    checks++; if (bus.A3 !== 4'd0) begin failures++; $display("FAIL reset_a3 actual=%h expected=0", bus.A3); end
    checks++; if (bus.WD3 !== 32'd0) begin failures++; $display("FAIL reset_wd3 actual=%h expected=0", bus.WD3); end
    checks++; if (bus.pc_wd !== 32'd0) begin failures++; $display("FAIL reset_pc_wd actual=%h expected=0", bus.pc_wd); end
    advance();
    reset = 1'b0;
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL reset_idle_we3 actual=%b expected=0", bus.WE3); end
    advance();
  endtask

  task automatic test_single();
    set_req(2'b01, 3, 0, 32'hA5A5_0001, 0);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL single_gnt actual=%b expected=01", bus.gnt); end
    advance();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("FAIL single_we3 actual=%b expected=1", bus.WE3); end
    checks++; if (bus.A3 !== 4'd3) begin failures++; $display("FAIL single_a3 actual=%h expected=3", bus.A3); end
    checks++; if (bus.WD3 !== 32'hA5A5_0001) begin failures++; $display("FAIL single_wd3 actual=%h expected=a5a50001", bus.WD3); end
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL single_idle_gnt actual=%b expected=00", bus.gnt); end
    advance();
    @(negedge clk);
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL single_we3_drop actual=%b expected=0", bus.WE3); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_req(2'b11, 1, 2, 32'h100, 32'h200);
      else       set_req('0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 4) begin
        eg = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL b2b_gnt%0d actual=%b expected=%b", k, bus.gnt, eg); end
      end
      if (k >= 1 && k <= 4) begin
        ea = ((k - 1) % 2 == 0) ? 4'd1 : 4'd2;
        checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("FAIL b2b_we3_%0d actual=%b expected=1", k, bus.WE3); end
        checks++; if (bus.A3 !== ea) begin failures++; $display("FAIL b2b_a3_%0d actual=%h expected=%h", k, bus.A3, ea); end
      end
      if (k == 5) begin
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL b2b_we3_end actual=%b expected=0", bus.WE3); end
      end
      advance();
    end
  endtask

  task automatic test_pc_write();
    a1_v = 15;
    a2_v = 15;
    set_req(2'b01, 15, 0, 32'h0000_0040, 0);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL pc_gnt actual=%b expected=01", bus.gnt); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL pc_stall_req actual=%b expected=0", bus.stall); end
    advance();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.pc_we !== 1'b1) begin failures++; $display("FAIL pc_we actual=%b expected=1", bus.pc_we); end
    checks++; if (bus.pc_wd !== 32'h40) begin failures++; $display("FAIL pc_wd actual=%h expected=40", bus.pc_wd); end
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL pc_we3 actual=%b expected=0", bus.WE3); end
    checks++; if (bus.A3 !== 4'd2) begin failures++; $display("FAIL pc_a3_hold actual=%h expected=2", bus.A3); end
    checks++; if (bus.WD3 !== 32'h200) begin failures++; $display("FAIL pc_wd3_hold actual=%h expected=200", bus.WD3); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL pc_stall_out actual=%b expected=0", bus.stall); end
    advance();
    a1_v = 0;
    a2_v = 0;
    drive();
  endtask

  task automatic test_same_dest();
    do_reset();
    set_req(2'b11, 5, 5, 32'h11, 32'h22);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL same_gnt0 actual=%b expected=01", bus.gnt); end
    advance();
    set_req(2'b10, 5, 5, 32'h11, 32'h22);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL same_gnt1 actual=%b expected=10", bus.gnt); end
    advance();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    advance();
    checks++; if (obs_rf[5] !== 32'h22) begin failures++; $display("FAIL same_final actual=%h expected=22", obs_rf[5]); end
  endtask

  task automatic test_stall();
    do_reset();
    a1_v = 7;
    a2_v = 0;
    set_req(2'b11, 3, 7, 32'h33, 32'h77);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL stall_gnt0 actual=%b expected=01", bus.gnt); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_pending actual=%b expected=1", bus.stall); end
    advance();
    set_req(2'b10, 3, 7, 32'h33, 32'h77);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL stall_gnt1 actual=%b expected=10", bus.gnt); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_grant actual=%b expected=1", bus.stall); end
    advance();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.A3 !== 4'd7) begin failures++; $display("FAIL stall_a3 actual=%h expected=7", bus.A3); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_we3 actual=%b expected=1", bus.stall); end
    advance();
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_clear actual=%b expected=0", bus.stall); end
    advance();
    a1_v = 0;
    drive();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2'b01, 9, 0, 32'h99, 0);
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL mid_gnt0 actual=%b expected=01", bus.gnt); end
    advance();
    reset = 1'b1;
    set_req(2'b11, 4, 6, 32'h44, 32'h66);
    @(negedge clk);
    checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("FAIL mid_we3_inflight actual=%b expected=1", bus.WE3); end
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL mid_gnt_reset actual=%b expected=00", bus.gnt); end
    advance();
    reset = 1'b0;
    drive();
    @(negedge clk);
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL mid_we3_cancel actual=%b expected=0", bus.WE3); end
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL mid_gnt_after actual=%b expected=01", bus.gnt); end
    advance();
    set_req('0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.A3 !== 4'd4) begin failures++; $display("FAIL mid_a3_after actual=%h expected=4", bus.A3); end
    advance();
  endtask

  task automatic test_random();
    int              w;
    logic [NREQ-1:0] eg;
    logic            es;
    do_reset();
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_v[i]) begin
          if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          req_v[i]  = 1'b1;
          addr_v[i] = AW'($urandom_range(0, 15));
          data_v[i] = $urandom;
          waitc[i]  = 0;
        end
      end
      a1_v = AW'($urandom_range(0, 15));
      a2_v = AW'($urandom_range(0, 15));
      drive();
      @(negedge clk);
      w  = exp_winner();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      es = hazard_on(a1_v) | hazard_on(a2_v);
      for (int i = 0; i < NREQ; i++) if (req_v[i]) waitc[i]++;
      checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rnd_gnt c=%0d actual=%b expected=%b", c, bus.gnt, eg); end
      checks++; if (bus.stall !== es) begin failures++; $display("FAIL rnd_stall c=%0d actual=%b expected=%b", c, bus.stall, es); end
      checks++; if (bus.WE3 !== m_we) begin failures++; $display("FAIL rnd_we3 c=%0d actual=%b expected=%b", c, bus.WE3, m_we); end
      checks++; if (bus.A3 !== m_a3) begin failures++; $display("FAIL rnd_a3 c=%0d actual=%h expected=%h", c, bus.A3, m_a3); end
      checks++; if (bus.WD3 !== m_wd3) begin failures++; $display("FAIL rnd_wd3 c=%0d actual=%h expected=%h", c, bus.WD3, m_wd3); end
      checks++; if (bus.pc_we !== m_pcwe) begin failures++; $display("FAIL rnd_pc_we c=%0d actual=%b expected=%b", c, bus.pc_we, m_pcwe); end
      checks++; if (bus.pc_wd !== m_pcwd) begin failures++; $display("FAIL rnd_pc_wd c=%0d actual=%h expected=%h", c, bus.pc_wd, m_pcwd); end
      if (w >= 0) begin
        checks++; if (waitc[w] > NREQ) begin failures++; $display("FAIL rnd_fair c=%0d waited=%0d limit=%0d", c, waitc[w], NREQ); end
      end
      advance();
      if (w >= 0) req_v[w] = 1'b0;
      if (reset) req_v = '0;
    end
    reset = 1'b0;
    set_req('0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    a1_v  = 0;
    a2_v  = 0;
    for (int i = 0; i < 16; i++) obs_rf[i] = '0;
    set_req('0, 0, 0, 0, 0);
    m_last = NREQ - 1;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd3  = '0;
    m_pcwe = 1'b0;
    m_pcwd = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pc_write();
    test_same_dest();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) between NREQ writeback requesters, such as ALU result and load data, using round-robin arbitration. The winning write is registered into an output stage that drives the register file directly. Writes addressed to R15 (the PC) are diverted to a separate PC-write port and never reach the register file. A read-hazard stall output covers writes that are still in flight.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
DW, 32, data width
AW, 4, register address width (16 registers; address 15 is the PC)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; held until granted
addr  input  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW]
data  input  NREQ*DW  packed write data; requester i at [i*DW +: DW]
gnt  output  NREQ  one-hot grant, combinational, same cycle as selection
A1  input  AW  read address 1 currently presented to the register file
A2  input  AW  read address 2 currently presented to the register file
WE3  output  1  register-file write enable (registered)
A3  output  AW  register-file write address (registered)
WD3  output  DW  register-file write data (registered)
pc_we  output  1  PC write strobe (registered)
pc_wd  output  DW  PC write data (registered)
stall  output  1  read hazard on A1 or A2

Behaviour:
- Reset values: WE3=0, A3=0, WD3=0, pc_we=0, pc_wd=0, rr_ptr=NREQ-1. After reset, requester 0 has highest priority.
- gnt is forced to 0 while reset is high.
- Handshake:
  - Requester i asserts req[i] with addr/data stable.
  - A transfer occurs in the cycle gnt[i]=1.
  - The requester may change or drop req on the following cycle.
  - Dropping req before grant is legal; no state is retained for it.
- Arbitration (combinational):
  - Search starts at (rr_ptr+1) mod NREQ and wraps.
  - The first asserted req wins; exactly one gnt bit is high when any req is high.
  - On a grant, rr_ptr <= winner index at posedge. Otherwise rr_ptr is unchanged.
- Output stage (1-cycle latency):
  - Grant at cycle t gives outputs valid for cycle t+1. The register file commits at the end of cycle t+1.
  - If the winner's addr != 15: WE3=1, A3=addr, WD3=data, pc_we=0.
  - If the winner's addr == 15: pc_we=1, pc_wd=data, WE3=0. A3/WD3 hold their previous values.
  - With no grant, WE3=0 and pc_we=0 the next cycle. A3, WD3 and pc_wd hold their values.
- Arbiter throughput: one grant per cycle, with no bubbles between back-to-back grants.
- stall (combinational) = 1 when, for X in {A1, A2}, either:
  - WE3=1 and A3==X, or
  - any req[j]=1 with addr_j==X.
- Address 15 never raises stall; PC reads are handled outside this block.
- Same destination from two requesters in one cycle: only the RR winner is granted. The loser is granted on a later cycle, so both writes land in grant order.
- Fairness: a continuously asserted request is granted within NREQ cycles.
- Reset mid-operation: a write in the output stage is cancelled (WE3=0, pc_we=0 on the cycle after reset is sampled). Ungranted requests are not remembered.
- Address widths wrap naturally. No arithmetic on data; data passes unmodified.

Test Plan:
- Reset, then req=2'b01, addr0=3, data0=32'hA5A5_0001: gnt=01 in cycle 0. Cycle 1: WE3=1, A3=3, WD3=32'hA5A5_0001. Cycle 2: WE3=0.
- req=2'b11 held for 4 cycles with addr0=1 and addr1=2: gnt sequence is 01, 10, 01, 10. WE3 stays high for 4 consecutive cycles, with A3 sequence 1, 2, 1, 2, delayed by one cycle.
- addr0=15, data0=32'h0000_0040: pc_we=1 and pc_wd=32'h40 next cycle. WE3 stays 0 and stall stays 0.
- Both requesters target addr 5 with data 11 then 22: two grants in RR order. The register file ends holding the later grant's data.
- A1=7 while req1 is pending to 7: stall=1. It stays 1 for the grant cycle and the following WE3 cycle, then drops to 0.
- Reset asserted the cycle after a grant: WE3=0 on the next cycle, and rr_ptr returns to NREQ-1 (req0 wins first afterwards).
